// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin shared LCD character writer; LCD_ADDR_CACHE_EN skips redundant address bytes
module lcd_write_arbiter #(
  parameter int NREQ = 4,
  parameter logic [7:0] ROW2_BASE = 8'h40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_done,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_row,
  input  logic [4*NREQ-1:0]   req_col,
  input  logic [8*NREQ-1:0]   req_char,
  output logic [NREQ-1:0]     ack,
  output logic                busy,
  output logic                cmd_valid,
  output logic                cmd_rs,
  output logic [7:0]          cmd_data,
  input  logic                cmd_ready
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, SEND_ADDR, SEND_CHAR, ACK} state_t;
  state_t          state_q;
  logic [GW-1:0]   rr_q, g_q, g_d, idx;
  logic [NREQ-1:0] ack_q;
  logic            busy_q, cmd_valid_q, cmd_rs_q, hit;
  logic [7:0]      cmd_data_q, char_q, char_d;
  logic [6:0]      addr_d;
`ifdef LCD_ADDR_CACHE_EN
  logic [6:0]      addr_q, cur_addr_q;
  logic            cur_valid_q, skip;
  assign skip = cur_valid_q && (addr_d == cur_addr_q);
`endif
  // first pending requester at or after rr, wrapping
  always_comb begin
    g_d = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = GW'((int'(rr_q) + i) % NREQ);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        g_d = idx;
      end
    end
    addr_d = (req_row[g_d] ? ROW2_BASE[6:0] : 7'h00) | {3'b000, req_col[{g_d, 2'b00} +: 4]};
    char_d = req_char[{g_d, 3'b000} +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      g_q         <= '0;
      char_q      <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_rs_q    <= 1'b0;
      cmd_data_q  <= '0;
`ifdef LCD_ADDR_CACHE_EN
      addr_q      <= '0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (init_done && |req) begin
          g_q         <= g_d;
          char_q      <= char_d;
          busy_q      <= 1'b1;
          cmd_valid_q <= 1'b1;
`ifdef LCD_ADDR_CACHE_EN
          addr_q      <= addr_d;
          state_q     <= skip ? SEND_CHAR : SEND_ADDR;
          cmd_rs_q    <= skip;
          cmd_data_q  <= skip ? char_d : {1'b1, addr_d};
`else
          state_q     <= SEND_ADDR;
          cmd_rs_q    <= 1'b0;
          cmd_data_q  <= {1'b1, addr_d};
`endif
        end
        SEND_ADDR: if (cmd_ready) begin
          state_q    <= SEND_CHAR;
          cmd_rs_q   <= 1'b1;
          cmd_data_q <= char_q;
        end
        SEND_CHAR: if (cmd_ready) begin
          state_q     <= ACK;
          cmd_valid_q <= 1'b0;
          cmd_rs_q    <= 1'b0;
          cmd_data_q  <= '0;
          ack_q       <= NREQ'(1) << g_q;
`ifdef LCD_ADDR_CACHE_EN
          cur_addr_q  <= addr_q + 7'd1;
          cur_valid_q <= 1'b1;
`endif
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          rr_q    <= (g_q == GW'(NREQ - 1)) ? '0 : g_q + 1'b1;
        end
      endcase
`ifdef LCD_ADDR_CACHE_EN
      if (!init_done) cur_valid_q <= 1'b0;
`endif
    end
  end
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_rs    = cmd_rs_q;
  assign cmd_data  = cmd_data_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed checks of arbitration, byte sequencing, backpressure, gating and reset
module tb_lcd_write_arbiter;
  logic        clk = 1'b0, rst = 1'b1, init_done = 1'b1, cmd_ready = 1'b1;
  logic [3:0]  req = '0, req_row = '0, ack;
  logic [15:0] req_col = '0;
  logic [31:0] req_char = '0;
  logic        busy, cmd_valid, cmd_rs;
  logic [7:0]  cmd_data;
  int checks = 0, failures = 0;
  lcd_write_arbiter #(.NREQ(4), .ROW2_BASE(8'h40)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .req(req), .req_row(req_row),
    .req_col(req_col), .req_char(req_char), .ack(ack), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cmd_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic row, input logic [3:0] col, input logic [7:0] ch);
    req_row[i] = row;
    req_col[4*i +: 4] = col;
    req_char[8*i +: 8] = ch;
    req[i] = 1'b1;
  endtask
  task automatic byte_chk(input string tag, input logic rs, input logic [7:0] d);
    chk({tag, "_valid"}, {31'b0, cmd_valid}, 32'd1);
    chk({tag, "_rs"}, {31'b0, cmd_rs}, {31'b0, rs});
    chk({tag, "_data"}, {24'b0, cmd_data}, {24'b0, d});
  endtask
  task automatic wait_ack(input string tag, input logic [3:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0 && n < 20);
    chk(tag, {28'b0, ack}, {28'b0, exp});
  endtask
  initial begin
    @(negedge clk);
    chk("rst_ack", {28'b0, ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_rs", {31'b0, cmd_rs}, 32'd0);
    chk("rst_data", {24'b0, cmd_data}, 32'd0);
    rst = 1'b0;
    // single write: row 1 col 5 -> 0xC5, then 0x41
    set_req(2, 1'b1, 4'd5, 8'h41);
    @(negedge clk); byte_chk("single_addr", 1'b0, 8'hC5);
    chk("single_busy", {31'b0, busy}, 32'd1);
    @(negedge clk); byte_chk("single_char", 1'b1, 8'h41);
    @(negedge clk);
    chk("single_ack", {28'b0, ack}, 32'h4);
    chk("single_ack_valid", {31'b0, cmd_valid}, 32'd0);
    req = '0;
    @(negedge clk);
    chk("single_ack_pulse", {28'b0, ack}, 32'd0);
    chk("single_idle_busy", {31'b0, busy}, 32'd0);
    // contention from fresh reset: order 0,1,3 repeating
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b0, 4'd0, 8'h30);
    set_req(1, 1'b0, 4'd1, 8'h31);
    set_req(3, 1'b1, 4'd3, 8'h33);
    for (int k = 0; k < 6; k++) begin
      wait_ack("contend_ack", (k % 3 == 0) ? 4'h1 : (k % 3 == 1) ? 4'h2 : 4'h8);
      if (k == 5) req = '0;
      @(negedge clk);
      chk("contend_ack_pulse", {28'b0, ack}, 32'd0);
    end
    // backpressure: address byte held 5 extra cycles
    cmd_ready = 1'b0;
    set_req(0, 1'b0, 4'd7, 8'h5A);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); byte_chk("bp_hold", 1'b0, 8'h87);
    end
    @(negedge clk); byte_chk("bp_hold_last", 1'b0, 8'h87);
    cmd_ready = 1'b1;
    @(negedge clk); byte_chk("bp_char", 1'b1, 8'h5A);
    @(negedge clk);
    chk("bp_ack", {28'b0, ack}, 32'h1);
    req = '0;
    // init_done gating
    init_done = 1'b0;
    set_req(0, 1'b0, 4'd2, 8'h44);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("gate_valid", {31'b0, cmd_valid}, 32'd0);
      chk("gate_busy", {31'b0, busy}, 32'd0);
    end
    init_done = 1'b1;
    @(negedge clk); byte_chk("gate_start", 1'b0, 8'h82);
    chk("gate_start_busy", {31'b0, busy}, 32'd1);
    @(negedge clk); byte_chk("gate_char", 1'b1, 8'h44);
    @(negedge clk);
    chk("gate_ack", {28'b0, ack}, 32'h1);
    req = '0;
    // async reset during SEND_CHAR of requester 1
    @(negedge clk);
    set_req(1, 1'b1, 4'd15, 8'h71);
    @(negedge clk); byte_chk("ar_addr", 1'b0, 8'hCF);
    @(negedge clk); byte_chk("ar_char", 1'b1, 8'h71);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, cmd_valid}, 32'd0);
    chk("ar_ack", {28'b0, ack}, 32'd0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b1;
    wait_ack("ar_rr_first", 4'h1);
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk); byte_chk("ar_re_addr", 1'b0, 8'hCF);
    @(negedge clk); byte_chk("ar_re_char", 1'b1, 8'h71);
    @(negedge clk);
    chk("ar_re_ack", {28'b0, ack}, 32'h2);
    req = '0;
`ifdef LCD_ADDR_CACHE_EN
    @(negedge clk);
    set_req(0, 1'b0, 4'd3, 8'h41);
    @(negedge clk); byte_chk("cache_addr1", 1'b0, 8'h83);
    @(negedge clk); byte_chk("cache_char1", 1'b1, 8'h41);
    @(negedge clk);
    chk("cache_ack1", {28'b0, ack}, 32'h1);
    req = '0;
    @(negedge clk);
    set_req(0, 1'b0, 4'd4, 8'h42);
    @(negedge clk); byte_chk("cache_skip", 1'b1, 8'h42);
    @(negedge clk);
    chk("cache_ack2", {28'b0, ack}, 32'h1);
    req = '0;
    @(negedge clk);
    set_req(0, 1'b0, 4'd9, 8'h43);
    @(negedge clk); byte_chk("cache_miss_addr", 1'b0, 8'h89);
    @(negedge clk); byte_chk("cache_miss_char", 1'b1, 8'h43);
    @(negedge clk);
    chk("cache_ack3", {28'b0, ack}, 32'h1);
    req = '0;
`endif
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single character LCD among NREQ requesters, each writing one character at a given (row, col).
- Round-robin arbitrates pending requests and converts the granted request into two LCD byte writes: a Set-DDRAM-Address command, then the character data.
- Sits between the application requesters and the LCD byte-level bus driver. The bus driver owns init, E timing and delays, and exposes a valid/ready byte interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ROW2_BASE, 8'h40, DDRAM base address of row 1 (row 0 base is 8'h00).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- init_done  in  1  high once the LCD driver has completed its power-up sequence.
- req  in  NREQ  per-requester write request; held high until the matching ack.
- req_row  in  NREQ  per-requester row select (0 = top, 1 = bottom).
- req_col  in  4*NREQ  per-requester column 0..15, packed with requester i at [4i+3:4i].
- req_char  in  8*NREQ  per-requester character code, packed with requester i at [8i+7:8i].
- ack  out  NREQ  one-cycle pulse marking the completion of requester i's write.
- busy  out  1  high while a transaction is in progress (any state other than IDLE).
- cmd_valid  out  1  a byte is offered to the LCD driver.
- cmd_rs  out  1  register select for the offered byte (0 = command, 1 = data).
- cmd_data  out  8  the offered byte.
- cmd_ready  in  1  the driver accepts the byte when cmd_valid and cmd_ready are high in the same cycle.

Behaviour:
- Reset values:
  - State: IDLE.
  - ack = 0, busy = 0, cmd_valid = 0, cmd_rs = 0, cmd_data = 8'h00.
  - Round-robin pointer rr = 0.
  - Latched payload cleared.
- Reset mid-transaction aborts the transaction immediately. No ack is issued, and the requester keeps req high and is re-arbitrated after reset.
- State machine:
  - IDLE: if init_done and |req, go to SEND_ADDR. In that same cycle:
    - select grant g = first i with req[i], searching from rr upward and wrapping mod NREQ;
    - latch g, row, col and char.
  - SEND_ADDR:
    - cmd_valid = 1, cmd_rs = 0.
    - cmd_data = 8'h80 | (row ? ROW2_BASE : 8'h00) | {4'b0, col}.
    - On handshake (cmd_valid & cmd_ready), go to SEND_CHAR.
  - SEND_CHAR:
    - cmd_valid = 1, cmd_rs = 1, cmd_data = latched char.
    - On handshake, go to ACK.
  - ACK:
    - ack[g] = 1 for exactly one cycle; cmd_valid = 0.
    - rr <= (g + 1) mod NREQ.
    - Next state: IDLE.
- Handshake rules:
  - cmd_valid, once high, stays high with cmd_rs and cmd_data stable until the handshake. It never drops early.
  - cmd_valid is never high in IDLE or ACK, so bytes are back-to-back at most, never overlapping.
- Payload latching:
  - Payload is latched at grant.
  - Changes on req_* during a transaction are ignored.
  - Requesters must hold req until ack. req deasserted mid-transaction does not cancel the write.
- Minimum latency: grant to ack = 3 cycles with cmd_ready tied high (IDLE, SEND_ADDR, SEND_CHAR, then ack in ACK).
- Back-to-back operation: a requester re-raising req the cycle after its ack competes normally. The round-robin guarantees every pending requester is served within NREQ transactions.
- init_done low:
  - No new grant.
  - A transaction already in progress completes normally.
- Column width: col is 4 bits, so addresses cover 0x00..0x0F and 0x40..0x4F. No out-of-range handling is required.

Optional Feature:
- Macro: LCD_ADDR_CACHE_EN
- Defined:
  - Adds a cursor cache: cur_addr (7 bits) plus cur_valid.
  - After each data handshake, cur_addr <= target address + 1 (mod 128) and cur_valid <= 1.
  - At grant, if cur_valid and the target address equals cur_addr, the FSM goes directly to SEND_CHAR and skips SEND_ADDR. This makes a sequential string write cost one byte per character.
  - cur_valid clears on rst and whenever init_done is low.
- Undefined: every transaction sends both bytes. No cache registers exist.

Test Plan:
- Single write, cmd_ready = 1, NREQ = 4:
  - Stimulus: req[2], row 1, col 5, char 8'h41.
  - Required: bytes (rs0, 8'hC5) then (rs1, 8'h41); ack[2] pulses 3 cycles after grant; busy low afterwards.
- Contention:
  - Stimulus: req = 4'b1011 held continuously.
  - Required: grant order 0, 1, 3, 0, 1, 3; exactly one ack per transaction.
- Backpressure:
  - Stimulus: cmd_ready low for 5 cycles during SEND_ADDR.
  - Required: cmd_valid, cmd_rs and cmd_data held constant; byte order unchanged; ack delayed by 5 cycles.
- init_done gating:
  - Stimulus: init_done = 0 with req[0] = 1.
  - Required: no cmd_valid, busy = 0.
  - Stimulus: raise init_done.
  - Required: transaction starts in the next cycle.
- Async reset:
  - Stimulus: assert rst during SEND_CHAR.
  - Required: cmd_valid and ack drop immediately; rr = 0.
  - Stimulus: after reset, req[1] still held.
  - Required: requester 1 is re-served with both bytes.
- LCD_ADDR_CACHE_EN:
  - Stimulus: requester 0 writes row 0, col 3 then col 4.
  - Required: first write sends 2 bytes (8'h83, char); second write sends only the data byte.
  - Stimulus: a following write to col 9.
  - Required: sends address byte 8'h89.
